// File: rtl/axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// axi_write_arbiter : two-master to one-slave AXI3 write-path arbiter that
// holds one grant per transaction (AW, all W beats, B).
// Optional macro ARB_FIXED_PRIORITY_EN : master 0 wins every tie.
// Revision : 1.0
// ============================================================================
module axi_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ID_W-1:0]     m0_AWID,
   input  logic [31:0]         m0_AWADDR,
   input  logic [3:0]          m0_AWLEN,
   input  logic [2:0]          m0_AWSIZE,
   input  logic [1:0]          m0_AWBURST,
   input  logic [1:0]          m0_AWLOCK,
   input  logic [3:0]          m0_AWCACHE,
   input  logic [2:0]          m0_AWPROT,
   input  logic                m0_AWVALID,
   output logic                m0_AWREADY,
   input  logic [ID_W-1:0]     m0_WID,
   input  logic [DATA_W-1:0]   m0_WDATA,
   input  logic [DATA_W/8-1:0] m0_WSTRB,
   input  logic                m0_WLAST,
   input  logic                m0_WVALID,
   output logic                m0_WREADY,
   output logic [ID_W-1:0]     m0_BID,
   output logic [1:0]          m0_BRESP,
   output logic                m0_BVALID,
   input  logic                m0_BREADY,
   input  logic [ID_W-1:0]     m1_AWID,
   input  logic [31:0]         m1_AWADDR,
   input  logic [3:0]          m1_AWLEN,
   input  logic [2:0]          m1_AWSIZE,
   input  logic [1:0]          m1_AWBURST,
   input  logic [1:0]          m1_AWLOCK,
   input  logic [3:0]          m1_AWCACHE,
   input  logic [2:0]          m1_AWPROT,
   input  logic                m1_AWVALID,
   output logic                m1_AWREADY,
   input  logic [ID_W-1:0]     m1_WID,
   input  logic [DATA_W-1:0]   m1_WDATA,
   input  logic [DATA_W/8-1:0] m1_WSTRB,
   input  logic                m1_WLAST,
   input  logic                m1_WVALID,
   output logic                m1_WREADY,
   output logic [ID_W-1:0]     m1_BID,
   output logic [1:0]          m1_BRESP,
   output logic                m1_BVALID,
   input  logic                m1_BREADY,
   output logic [ID_W-1:0]     s_AWID,
   output logic [31:0]         s_AWADDR,
   output logic [3:0]          s_AWLEN,
   output logic [2:0]          s_AWSIZE,
   output logic [1:0]          s_AWBURST,
   output logic [1:0]          s_AWLOCK,
   output logic [3:0]          s_AWCACHE,
   output logic [2:0]          s_AWPROT,
   output logic                s_AWVALID,
   input  logic                s_AWREADY,
   output logic [ID_W-1:0]     s_WID,
   output logic [DATA_W-1:0]   s_WDATA,
   output logic [DATA_W/8-1:0] s_WSTRB,
   output logic                s_WLAST,
   output logic                s_WVALID,
   input  logic                s_WREADY,
   input  logic [ID_W-1:0]     s_BID,
   input  logic [1:0]          s_BRESP,
   input  logic                s_BVALID,
   output logic                s_BREADY,
   output logic [1:0]          grant,
   output logic                busy,
   output logic                wlast_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] len_q;
   logic [3:0] beat_cnt;
   logic       last_grant;
   logic       sel_m1;
   logic       pick_m1;
   logic       aw_hs;
   logic       w_hs;
   logic       b_hs;

   // Routing follows the grant register; master 0 is the default path when idle.
   assign sel_m1 = grant[1];

   always_comb begin
`ifdef ARB_FIXED_PRIORITY_EN
      pick_m1 = m1_AWVALID && !m0_AWVALID;
`else
      pick_m1 = m1_AWVALID && (!m0_AWVALID || !last_grant);
`endif
   end

   assign s_AWID     = sel_m1 ? m1_AWID    : m0_AWID;
   assign s_AWADDR   = sel_m1 ? m1_AWADDR  : m0_AWADDR;
   assign s_AWLEN    = sel_m1 ? m1_AWLEN   : m0_AWLEN;
   assign s_AWSIZE   = sel_m1 ? m1_AWSIZE  : m0_AWSIZE;
   assign s_AWBURST  = sel_m1 ? m1_AWBURST : m0_AWBURST;
   assign s_AWLOCK   = sel_m1 ? m1_AWLOCK  : m0_AWLOCK;
   assign s_AWCACHE  = sel_m1 ? m1_AWCACHE : m0_AWCACHE;
   assign s_AWPROT   = sel_m1 ? m1_AWPROT  : m0_AWPROT;
   assign s_AWVALID  = (state == ADDR) && (sel_m1 ? m1_AWVALID : m0_AWVALID);
   assign m0_AWREADY = (state == ADDR) && grant[0] && s_AWREADY;
   assign m1_AWREADY = (state == ADDR) && grant[1] && s_AWREADY;

   assign s_WID      = sel_m1 ? m1_WID   : m0_WID;
   assign s_WDATA    = sel_m1 ? m1_WDATA : m0_WDATA;
   assign s_WSTRB    = sel_m1 ? m1_WSTRB : m0_WSTRB;
   assign s_WLAST    = sel_m1 ? m1_WLAST : m0_WLAST;
   assign s_WVALID   = (state == DATA) && (sel_m1 ? m1_WVALID : m0_WVALID);
   assign m0_WREADY  = (state == DATA) && grant[0] && s_WREADY;
   assign m1_WREADY  = (state == DATA) && grant[1] && s_WREADY;

   assign m0_BID     = s_BID;
   assign m0_BRESP   = s_BRESP;
   assign m1_BID     = s_BID;
   assign m1_BRESP   = s_BRESP;
   assign m0_BVALID  = (state == RESP) && grant[0] && s_BVALID;
   assign m1_BVALID  = (state == RESP) && grant[1] && s_BVALID;
   assign s_BREADY   = (state == RESP) && (sel_m1 ? m1_BREADY : m0_BREADY);

   assign aw_hs = s_AWVALID && s_AWREADY;
   assign w_hs  = s_WVALID && s_WREADY;
   assign b_hs  = s_BVALID && s_BREADY;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= IDLE;
         grant      <= 2'b00;
         busy       <= 1'b0;
         wlast_err  <= 1'b0;
         beat_cnt   <= 4'd0;
         len_q      <= 4'd0;
         last_grant <= 1'b1;
      end else begin
         wlast_err <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_AWVALID || m1_AWVALID) begin
                  grant <= pick_m1 ? 2'b10 : 2'b01;
                  state <= ADDR;
                  busy  <= 1'b1;
               end
            end
            ADDR: begin
               if (aw_hs) begin
                  len_q    <= s_AWLEN;
                  beat_cnt <= 4'd0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  beat_cnt  <= beat_cnt + 4'd1;
                  // WLAST must coincide exactly with beat number AWLEN (mod 16).
                  wlast_err <= s_WLAST != (beat_cnt == len_q);
                  if (s_WLAST) state <= RESP;
               end
            end
            RESP: begin
               if (b_hs) begin
                  last_grant <= grant[1];
                  grant      <= 2'b00;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_arbiter.sv
`default_nettype none
// tb_axi_write_arbiter : randomized rounds of contending write transactions;
// a service-order model feeds a scoreboard that a negedge monitor drains.
module tb_axi_write_arbiter;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
`ifdef ARB_FIXED_PRIORITY_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic ACLK = 1'b0;
   logic ARESET;
   always #5 ACLK = ~ACLK;

   logic [ID_W-1:0]     awid    [2];
   logic [31:0]         awaddr  [2];
   logic [3:0]          awlen   [2];
   logic [2:0]          awsize  [2];
   logic [1:0]          awburst [2];
   logic [1:0]          awlock  [2];
   logic [3:0]          awcache [2];
   logic [2:0]          awprot  [2];
   logic                awvalid [2];
   logic [ID_W-1:0]     wid     [2];
   logic [DATA_W-1:0]   wdata   [2];
   logic [DATA_W/8-1:0] wstrb   [2];
   logic                wlast   [2];
   logic                wvalid  [2];
   logic                bready  [2];

   logic m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
   logic [ID_W-1:0] m0_bid, m1_bid;
   logic [1:0]      m0_bresp, m1_bresp;

   logic [ID_W-1:0]     s_awid, s_wid, s_bid;
   logic [31:0]         s_awaddr;
   logic [3:0]          s_awlen, s_awcache;
   logic [2:0]          s_awsize, s_awprot;
   logic [1:0]          s_awburst, s_awlock, s_bresp;
   logic                s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic                s_bvalid, s_bready;
   logic [DATA_W-1:0]   s_wdata;
   logic [DATA_W/8-1:0] s_wstrb;
   logic [1:0]          grant;
   logic                busy, wlast_err;

   axi_write_arbiter #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .m0_AWID(awid[0]), .m0_AWADDR(awaddr[0]), .m0_AWLEN(awlen[0]), .m0_AWSIZE(awsize[0]),
      .m0_AWBURST(awburst[0]), .m0_AWLOCK(awlock[0]), .m0_AWCACHE(awcache[0]), .m0_AWPROT(awprot[0]),
      .m0_AWVALID(awvalid[0]), .m0_AWREADY(m0_awready),
      .m0_WID(wid[0]), .m0_WDATA(wdata[0]), .m0_WSTRB(wstrb[0]), .m0_WLAST(wlast[0]),
      .m0_WVALID(wvalid[0]), .m0_WREADY(m0_wready),
      .m0_BID(m0_bid), .m0_BRESP(m0_bresp), .m0_BVALID(m0_bvalid), .m0_BREADY(bready[0]),
      .m1_AWID(awid[1]), .m1_AWADDR(awaddr[1]), .m1_AWLEN(awlen[1]), .m1_AWSIZE(awsize[1]),
      .m1_AWBURST(awburst[1]), .m1_AWLOCK(awlock[1]), .m1_AWCACHE(awcache[1]), .m1_AWPROT(awprot[1]),
      .m1_AWVALID(awvalid[1]), .m1_AWREADY(m1_awready),
      .m1_WID(wid[1]), .m1_WDATA(wdata[1]), .m1_WSTRB(wstrb[1]), .m1_WLAST(wlast[1]),
      .m1_WVALID(wvalid[1]), .m1_WREADY(m1_wready),
      .m1_BID(m1_bid), .m1_BRESP(m1_bresp), .m1_BVALID(m1_bvalid), .m1_BREADY(bready[1]),
      .s_AWID(s_awid), .s_AWADDR(s_awaddr), .s_AWLEN(s_awlen), .s_AWSIZE(s_awsize),
      .s_AWBURST(s_awburst), .s_AWLOCK(s_awlock), .s_AWCACHE(s_awcache), .s_AWPROT(s_awprot),
      .s_AWVALID(s_awvalid), .s_AWREADY(s_awready),
      .s_WID(s_wid), .s_WDATA(s_wdata), .s_WSTRB(s_wstrb), .s_WLAST(s_wlast),
      .s_WVALID(s_wvalid), .s_WREADY(s_wready),
      .s_BID(s_bid), .s_BRESP(s_bresp), .s_BVALID(s_bvalid), .s_BREADY(s_bready),
      .grant(grant), .busy(busy), .wlast_err(wlast_err)
   );

   typedef struct {
      int                          m;
      logic [ID_W-1:0]             id;
      logic [31:0]                 addr;
      logic [3:0]                  len;
      int                          nbeats;
      logic [15:0][DATA_W-1:0]     data;
   } txn_t;

   txn_t mq0[$];
   txn_t mq1[$];
   txn_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   last_srv = 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic txn_t make_txn(input int m, input int len, input int nbeats);
      txn_t t;
      t.m      = m;
      t.id     = ID_W'($urandom);
      t.addr   = $urandom;
      t.len    = 4'(len);
      t.nbeats = nbeats;
      for (int b = 0; b < 16; b++) t.data[b] = DATA_W'($urandom);
      return t;
   endfunction

   // A beat is in error when "is last" disagrees with "index equals AWLEN (mod 16)".
   function automatic int exp_errs(input txn_t t);
      int n = 0;
      for (int b = 0; b < t.nbeats; b++)
         if ((b == t.nbeats - 1) != ((b % 16) == int'(t.len))) n++;
      return n;
   endfunction

   function automatic bit hs_seen(input int m, input int ch);
      case (ch)
         0:       return 1'(awvalid[m] && (m == 0 ? m0_awready : m1_awready));
         1:       return 1'(wvalid[m] && (m == 0 ? m0_wready : m1_wready));
         default: return 1'(bready[m] && (m == 0 ? m0_bvalid : m1_bvalid));
      endcase
   endfunction

   task automatic wait_hs(input int m, input int ch);
      int cyc = 0;
      forever begin
         if (ch == 2) bready[m] = ($urandom_range(0, 3) != 0);
         @(negedge ACLK);
         if (hs_seen(m, ch)) break;
         cyc++;
         if (cyc > 500) begin
            fails++;
            $display("FAIL handshake_timeout: master %0d channel %0d got no handshake, required one within 500 cycles", m, ch);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "handshake timeout");
         end
         @(posedge ACLK); #1;
      end
   endtask

   task automatic drive(input int m, input int n);
      txn_t t;
      for (int k = 0; k < n; k++) begin
         t = (m == 0) ? mq0.pop_front() : mq1.pop_front();
         awid[m] = t.id; awaddr[m] = t.addr; awlen[m] = t.len;
         awsize[m] = 3'd2; awburst[m] = 2'd1; awvalid[m] = 1'b1;
         wait_hs(m, 0);
         @(posedge ACLK); #1;
         awvalid[m] = 1'b0;
         for (int b = 0; b < t.nbeats; b++) begin
            while ($urandom_range(0, 3) == 0) begin @(posedge ACLK); #1; end
            wid[m] = t.id; wdata[m] = t.data[b]; wstrb[m] = '1;
            wlast[m] = (b == t.nbeats - 1); wvalid[m] = 1'b1;
            wait_hs(m, 1);
            @(posedge ACLK); #1;
            wvalid[m] = 1'b0; wlast[m] = 1'b0;
         end
         wait_hs(m, 2);
         @(posedge ACLK); #1;
         bready[m] = 1'b0;
      end
   endtask

   // Service order: a lone requester wins; on a tie the master not served last
   // wins (or master 0 under fixed priority). A finishing master re-requests at once.
   task automatic run_round(input int n0, input int n1);
      int p0 = n0, p1 = n1, i0 = 0, i1 = 0, pick = 0;
      logic [1:0] first_g = 2'b00;
      while (p0 > 0 || p1 > 0) begin
         if (p0 > 0 && p1 > 0) pick = FIXED ? 0 : (last_srv == 0 ? 1 : 0);
         else                  pick = (p0 > 0) ? 0 : 1;
         if (pick == 0) begin exp_q.push_back(mq0[i0]); i0++; p0--; end
         else           begin exp_q.push_back(mq1[i1]); i1++; p1--; end
         if (i0 + i1 == 1) first_g = (pick == 0) ? 2'b01 : 2'b10;
         last_srv = pick;
      end
      fork
         drive(0, n0);
         drive(1, n1);
         begin
            @(negedge ACLK); chk("grant_before_edge", 64'(grant), 64'(2'b00));
            @(negedge ACLK); chk("grant_latency", 64'(grant), 64'(first_g));
         end
      join
   endtask

   // Slave: random AW/W ready, B response 0..5 cycles after WLAST echoing AWID.
   initial begin
      int bdelay;
      logic [ID_W-1:0] cap_id;
      bit bhs;
      bdelay = -1; cap_id = '0;
      s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bid = '0; s_bresp = 2'b00;
      forever begin
         @(negedge ACLK);
         bhs = s_bvalid && s_bready;
         if (s_awvalid && s_awready) cap_id = s_awid;
         if (s_wvalid && s_wready && s_wlast) bdelay = $urandom_range(0, 5);
         if (ARESET) bdelay = -1;
         @(posedge ACLK); #1;
         if (bhs || ARESET) s_bvalid = 1'b0;
         if (bdelay == 0) begin
            s_bvalid = 1'b1; s_bid = cap_id; s_bresp = 2'($urandom); bdelay = -1;
         end else if (bdelay > 0) bdelay--;
         s_awready = ($urandom_range(0, 2) != 0);
         s_wready  = 1'($urandom_range(0, 1));
      end
   end

   bit   mon_en = 1'b0;
   bit   active = 1'b0;
   bit   chk_idle = 1'b0;
   txn_t cur;
   int   beat = 0;
   int   err_cnt = 0;

   always @(negedge ACLK) begin
      if (mon_en) begin
         if (wlast_err) err_cnt++;
         if (chk_idle) begin
            chk("idle_grant", 64'(grant), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
            chk_idle = 1'b0;
         end
         if (!active) chk("fwd_outside_txn", 64'({s_wvalid, s_bready}), 64'(0));
         else begin
            chk("other_master_quiet", 64'(cur.m == 0 ? {m1_awready, m1_wready, m1_bvalid}
                                                     : {m0_awready, m0_wready, m0_bvalid}), 64'(0));
            chk("aw_after_addr", 64'(s_awvalid), 64'(0));
         end
         if (s_awvalid && s_awready) begin
            if (active || exp_q.size() == 0) chk("aw_unexpected", 64'(1), 64'(0));
            else begin
               cur = exp_q.pop_front();
               active = 1'b1; beat = 0;
               chk("aw_grant", 64'(grant), 64'(cur.m == 0 ? 2'b01 : 2'b10));
               chk("aw_addr", 64'(s_awaddr), 64'(cur.addr));
               chk("aw_id", 64'(s_awid), 64'(cur.id));
               chk("aw_len", 64'(s_awlen), 64'(cur.len));
            end
         end
         if (s_wvalid && s_wready) begin
            if (!active) chk("w_unexpected", 64'(1), 64'(0));
            else begin
               chk("w_data", 64'(s_wdata), 64'(cur.data[beat % 16]));
               chk("w_last", 64'(s_wlast), 64'(beat == cur.nbeats - 1));
               chk("w_id", 64'(s_wid), 64'(cur.id));
               beat++;
            end
         end
         if (s_bvalid && s_bready) begin
            if (!active) chk("b_unexpected", 64'(1), 64'(0));
            else begin
               chk("b_valid", 64'(cur.m == 0 ? m0_bvalid : m1_bvalid), 64'(1));
               chk("b_id", 64'(cur.m == 0 ? m0_bid : m1_bid), 64'(cur.id));
               chk("b_resp", 64'(cur.m == 0 ? m0_bresp : m1_bresp), 64'(s_bresp));
               chk("beat_count", 64'(beat), 64'(cur.nbeats));
               chk("wlast_err_pulses", 64'(err_cnt), 64'(exp_errs(cur)));
               err_cnt = 0; active = 1'b0; chk_idle = 1'b1;
            end
         end
      end
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len, nb, n0, n1;
      for (int m = 0; m < 2; m++) begin
         awid[m] = '0; awaddr[m] = '0; awlen[m] = '0; awsize[m] = '0; awburst[m] = '0;
         awlock[m] = '0; awcache[m] = '0; awprot[m] = '0; awvalid[m] = 1'b0;
         wid[m] = '0; wdata[m] = '0; wstrb[m] = '0; wlast[m] = 1'b0; wvalid[m] = 1'b0;
         bready[m] = 1'b0;
      end
      ARESET = 1'b1;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_wlast_err", 64'(wlast_err), 64'(0));
      chk("rst_valids", 64'({s_awvalid, s_wvalid, s_bready, m0_awready, m1_awready,
                             m0_wready, m1_wready, m0_bvalid, m1_bvalid}), 64'(0));
      @(posedge ACLK); #1;
      mon_en = 1'b1;

      // Tie straight after reset: master 0 first, then master 1.
      mq0.push_back(make_txn(0, 0, 1)); mq1.push_back(make_txn(1, 0, 1));
      run_round(1, 1);
      mq0.push_back(make_txn(0, 3, 4));
      run_round(1, 0);
      mq0.push_back(make_txn(0, 3, 2));   // early WLAST
      run_round(1, 0);
      mq1.push_back(make_txn(1, 1, 3));   // missing WLAST on beat 2
      run_round(0, 1);
      // Master 0 re-requests back-to-back while master 1 waits.
      mq0.push_back(make_txn(0, 1, 2)); mq0.push_back(make_txn(0, 2, 3));
      mq1.push_back(make_txn(1, 0, 1));
      run_round(2, 1);

      for (int r = 0; r < 40; r++) begin
         n0 = $urandom_range(0, 2);
         n1 = $urandom_range(0, 2);
         if (n0 == 0 && n1 == 0) n1 = 1;
         for (int k = 0; k < n0 + n1; k++) begin
            len = $urandom_range(0, 7);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 2) : len + 1;
            if (k < n0) mq0.push_back(make_txn(0, len, nb));
            else        mq1.push_back(make_txn(1, len, nb));
         end
         repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
         run_round(n0, n1);
      end

      // Reset after the second data beat of a four-beat burst.
      mon_en = 1'b0;
      awid[0] = 4'h5; awaddr[0] = 32'h1234_0000; awlen[0] = 4'd3; awvalid[0] = 1'b1;
      wait_hs(0, 0);
      @(posedge ACLK); #1;
      awvalid[0] = 1'b0;
      for (int b = 0; b < 2; b++) begin
         wdata[0] = $urandom; wlast[0] = 1'b0; wvalid[0] = 1'b1;
         wait_hs(0, 1);
         @(posedge ACLK); #1;
         wvalid[0] = 1'b0;
      end
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_grant", 64'(grant), 64'(0));
      chk("rst_mid_valids", 64'({s_awvalid, s_wvalid, s_bready}), 64'(0));
      chk("rst_mid_wlast_err", 64'(wlast_err), 64'(0));
      @(posedge ACLK); #1;
      last_srv = 1; err_cnt = 0; active = 1'b0; chk_idle = 1'b0;
      mon_en = 1'b1;
      mq0.push_back(make_txn(0, 2, 3)); mq1.push_back(make_txn(1, 1, 2));
      run_round(1, 1);

      repeat (4) @(posedge ACLK);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
